clk_seg_display_mux: RTL and testbench



---
 rtl/clk_seg_display_mux.sv | 116 +++++++++++
 tb/tb_clk_seg_display_mux.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_seg_display_mux.sv
// Time-multiplexed MM.SS driver for a 4-digit common-anode 7-segment display.
// Optional macro LEAD_ZERO_BLANK_EN blanks a zero minutes-tens digit.
module clk_seg_display_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] seconds_in,
  input  logic [5:0] minutes_in,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic [3:0] an_out,
  output logic       frame_tick
);
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [3:0] DASH  = 4'hA;
  localparam logic [3:0] BLANK = 4'hF;

  typedef enum logic {DEAD, ON} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [5:0]    sec_snap, min_snap, sec_nxt, min_nxt;
  logic          wrap, capture, sec_bad, min_bad;
  logic [3:0]    code;

  // Active-high g..a pattern; unknown codes decode to a dash, BLANK to nothing.
  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'h3F;
      4'd1:    enc = 7'h06;
      4'd2:    enc = 7'h5B;
      4'd3:    enc = 7'h4F;
      4'd4:    enc = 7'h66;
      4'd5:    enc = 7'h6D;
      4'd6:    enc = 7'h7D;
      4'd7:    enc = 7'h07;
      4'd8:    enc = 7'h7F;
      4'd9:    enc = 7'h6F;
      BLANK:   enc = 7'h00;
      default: enc = 7'h40;
    endcase
  endfunction

  // Outputs are registered from next-state values so they line up with cnt.
  always_comb begin
    wrap    = (cnt == CW'(REFRESH_DIV - 1));
    cnt_nxt = wrap ? '0 : cnt + 1'b1;
    idx_nxt = wrap ? idx + 2'd1 : idx;
    capture = (cnt == '0) && (idx == 2'd0);
    sec_nxt = capture ? seconds_in : sec_snap;
    min_nxt = capture ? minutes_in : min_snap;
    sec_bad = (sec_nxt > 6'd59);
    min_bad = (min_nxt > 6'd59);
  end

  always_comb begin
    code = DASH;
    case (idx_nxt)
      2'd0: code = sec_bad ? DASH : 4'(sec_nxt % 6'd10);
      2'd1: code = sec_bad ? DASH : 4'(sec_nxt / 6'd10);
      2'd2: code = min_bad ? DASH : 4'(min_nxt % 6'd10);
      default: begin
        code = min_bad ? DASH : 4'(min_nxt / 6'd10);
`ifdef LEAD_ZERO_BLANK_EN
        if (!min_bad && code == 4'd0) code = BLANK;
`else
`endif
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DEAD: if (DEAD_CYCLES == 0 || cnt_nxt == CW'(DEAD_CYCLES)) state_nxt = ON;
      ON:   if (wrap && DEAD_CYCLES != 0) state_nxt = DEAD;
      default: state_nxt = DEAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= DEAD;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      sec_snap   <= '0;
      min_snap   <= '0;
      an_out     <= 4'hF;
      seg_out    <= 7'h7F;
      dp_out     <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      sec_snap   <= sec_nxt;
      min_snap   <= min_nxt;
      frame_tick <= capture;
      if (state_nxt == ON) begin
        an_out  <= ~(4'b0001 << idx_nxt);
        seg_out <= ~enc(code);
        dp_out  <= (idx_nxt != 2'd2);
      end else begin
        an_out  <= 4'hF;
        seg_out <= 7'h7F;
        dp_out  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_clk_seg_display_mux.sv
// Directed bench for clk_seg_display_mux with REFRESH_DIV=20, DEAD_CYCLES=4.
module tb_clk_seg_display_mux;
  localparam int RD = 20;
  localparam int DC = 4;
`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [6:0] Z3 = 7'h7F;
`else
  localparam logic [6:0] Z3 = ~7'h3F;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] seconds_in = '0;
  logic [5:0] minutes_in = '0;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [3:0] an_out;
  logic       frame_tick;
  int checks = 0;
  int errors = 0;
  int n = 0;  // edges since reset release; after edge n, phase counter = n % RD

  clk_seg_display_mux #(.REFRESH_DIV(RD), .DEAD_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .seconds_in(seconds_in), .minutes_in(minutes_in),
    .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
    n += k;
  endtask

  task automatic goto(input int t);
    if (t > n) tick(t - n);
  endtask

  task automatic test_reset;
    reset = 1'b1; seconds_in = 6'd34; minutes_in = 6'd12;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({an_out, seg_out, dp_out, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_hold cyc %0d got an=%b seg=%h dp=%b ft=%b", i, an_out, seg_out, dp_out, frame_tick);
      end
    end
    reset = 1'b0; n = 0;
    checks++;
    if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_ft_c1 got %b exp 0", frame_tick); end
    tick(1);
    checks++;
    if (frame_tick !== 1'b1) begin errors++; $display("FAIL reset_ft_c2 got %b exp 1", frame_tick); end
    tick(1);
    checks++;
    if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_ft_c3 got %b exp 0", frame_tick); end
  endtask

  task automatic test_nominal;
    logic [3:0] ae[4];
    logic [6:0] se[4];
    logic       de[4];
    ae = '{4'hE, 4'hD, 4'hB, 4'h7};
    se = '{~7'h66, ~7'h4F, ~7'h5B, ~7'h06};
    de = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < DC; c++) begin
        goto(80 + RD*d + c);
        checks++;
        if (an_out !== 4'hF || seg_out !== 7'h7F) begin
          errors++;
          $display("FAIL nominal_dead d%0d c%0d got an=%b seg=%h exp an=1111 seg=7f", d, c, an_out, seg_out);
        end
      end
      for (int c = DC; c < RD; c += RD - 1 - DC) begin
        goto(80 + RD*d + c);
        checks++;
        if ({an_out, seg_out, dp_out} !== {ae[d], se[d], de[d]}) begin
          errors++;
          $display("FAIL nominal_on d%0d c%0d got an=%b seg=%h dp=%b exp an=%b seg=%h dp=%b",
                   d, c, an_out, seg_out, dp_out, ae[d], se[d], de[d]);
        end
      end
    end
  endtask

  task automatic test_mid_frame;
    logic [6:0] se[4];
    int pulse_at;
    goto(161);
    checks++;
    if (frame_tick !== 1'b1) begin errors++; $display("FAIL mid_ft_first got %b exp 1", frame_tick); end
    goto(185);
    seconds_in = 6'd59; minutes_in = 6'd45;
    goto(204);
    checks++;
    if ({an_out, seg_out, dp_out} !== {4'hB, ~7'h5B, 1'b0}) begin
      errors++; $display("FAIL mid_same_d2 got an=%b seg=%h dp=%b exp an=1011 seg=24 dp=0", an_out, seg_out, dp_out);
    end
    goto(224);
    checks++;
    if ({an_out, seg_out} !== {4'h7, ~7'h06}) begin
      errors++; $display("FAIL mid_same_d3 got an=%b seg=%h exp an=0111 seg=79", an_out, seg_out);
    end
    pulse_at = -1;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (frame_tick === 1'b1) begin pulse_at = n; break; end
    end
    checks++;
    if (pulse_at != 241) begin errors++; $display("FAIL mid_ft_period got pulse at %0d exp 241", pulse_at); end
    se = '{~7'h6F, ~7'h6D, ~7'h6D, ~7'h66};
    for (int d = 0; d < 4; d++) begin
      goto(240 + RD*d + DC);
      checks++;
      if (seg_out !== se[d]) begin
        errors++; $display("FAIL mid_new_frame d%0d got seg=%h exp %h", d, seg_out, se[d]);
      end
    end
  endtask

  task automatic test_out_of_range;
    logic [6:0] se[4];
    goto(305);
    seconds_in = 6'd62; minutes_in = 6'd7;
    se = '{~7'h40, ~7'h40, ~7'h07, Z3};
    for (int d = 0; d < 4; d++) begin
      goto(320 + RD*d + DC);
      checks++;
      if (seg_out !== se[d] || an_out !== ~(4'b0001 << d)) begin
        errors++; $display("FAIL oor d%0d got an=%b seg=%h exp seg=%h", d, an_out, seg_out, se[d]);
      end
    end
  endtask

  task automatic test_wrap;
    logic [6:0] se[4];
    int d, c;
    goto(385);
    seconds_in = 6'd59; minutes_in = 6'd59;
    se = '{~7'h6F, ~7'h6D, ~7'h6F, ~7'h6D};
    goto(404);
    checks++;
    if (seg_out !== se[0]) begin errors++; $display("FAIL wrap59_d0 got %h exp %h", seg_out, se[0]); end
    goto(424);
    checks++;
    if (seg_out !== se[1]) begin errors++; $display("FAIL wrap59_d1 got %h exp %h", seg_out, se[1]); end
    seconds_in = 6'd0; minutes_in = 6'd0;
    while (n < 479) begin
      tick(1);
      d = (n - 400) / RD; c = n % RD;
      if (c >= DC) begin
        checks++;
        if (seg_out !== se[d]) begin
          errors++; $display("FAIL wrap_torn n=%0d got %h exp %h", n, seg_out, se[d]);
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      goto(480 + RD*k + DC);
      checks++;
      if (seg_out !== ~7'h3F) begin errors++; $display("FAIL wrap00_d%0d got %h exp 40", k, seg_out); end
    end
  endtask

  task automatic test_reset_mid;
    goto(525);
    checks++;
    if (an_out !== 4'hB || dp_out !== 1'b0) begin
      errors++; $display("FAIL rstmid_pre got an=%b dp=%b exp an=1011 dp=0", an_out, dp_out);
    end
    reset = 1'b1; seconds_in = 6'd34; minutes_in = 6'd12;
    tick(1);
    checks++;
    if ({an_out, seg_out, dp_out, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++; $display("FAIL rstmid_edge got an=%b seg=%h dp=%b ft=%b", an_out, seg_out, dp_out, frame_tick);
    end
    reset = 1'b0; n = 0;
    tick(1);
    checks++;
    if (frame_tick !== 1'b1) begin errors++; $display("FAIL rstmid_ft got %b exp 1", frame_tick); end
    goto(DC);
    checks++;
    if ({an_out, seg_out} !== {4'hE, ~7'h66}) begin
      errors++; $display("FAIL rstmid_d0 got an=%b seg=%h exp an=1110 seg=19", an_out, seg_out);
    end
    goto(RD + DC);
    checks++;
    if ({an_out, seg_out} !== {4'hD, ~7'h4F}) begin
      errors++; $display("FAIL rstmid_d1 got an=%b seg=%h exp an=1101 seg=30", an_out, seg_out);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_mid_frame();
    test_out_of_range();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
